// File: rtl/mm_boot_loader_if.sv
//------------------------------------------------------------------------------
// Module  : mm_boot_loader_if
// Brief   : Byte-stream handshake plus mm data-write port of the boot loader.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mm_boot_loader_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [1:0]  mm_wr;
    logic [31:0] mm_addr;
    logic [31:0] mm_data;

    // master: stream source and mm observer; slave: the loader itself
    modport master (output s_data, s_valid,
                    input  s_ready, mm_wr, mm_addr, mm_data);
    modport slave  (input  s_data, s_valid,
                    output s_ready, mm_wr, mm_addr, mm_data);
endinterface

`default_nettype wire

// File: rtl/mm_boot_loader.sv
//------------------------------------------------------------------------------
// Module  : mm_boot_loader
// Brief   : Packs an LE byte stream (count N, then N words) into mm word writes
//           and holds the CPU in reset until the whole image is written.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mm_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [1:0]  MM_WR_W   = 2'b11
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start_i,
    mm_boot_loader_if.slave  bus,
    output logic             cpu_rst_n_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [31:0]      words_loaded_o
);

    localparam logic [31:0] C_MAX_WORDS = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t      state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] n_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] words_q;
    logic        s_ready_q;
    logic [1:0]  mm_wr_q;
    logic        cpu_rst_n_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic        w_xfer;
    logic        w_last_byte;
    logic [31:0] w_hdr_word;
    logic [31:0] w_data_word;
    logic [31:0] w_words_inc;

    assign w_xfer      = bus.s_valid & s_ready_q;
    assign w_last_byte = (byte_cnt_q == 2'd3);
    // Bytes shift in from the top so byte0 ends up in [7:0] after four transfers
    assign w_hdr_word  = {bus.s_data, n_q[31:8]};
    assign w_data_word = {bus.s_data, data_q[31:8]};
    assign w_words_inc = words_q + 32'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= 2'd0;
            n_q         <= 32'd0;
            addr_q      <= 32'd0;
            data_q      <= 32'd0;
            words_q     <= 32'd0;
            s_ready_q   <= 1'b0;
            mm_wr_q     <= 2'b00;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start_i) begin
                        state_q     <= ST_HDR;
                        byte_cnt_q  <= 2'd0;
                        words_q     <= 32'd0;
                        s_ready_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        cpu_rst_n_q <= 1'b0;
                    end
                end

                ST_HDR: begin
                    if (w_xfer) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        n_q        <= w_hdr_word;
                        if (w_last_byte) begin
                            if (w_hdr_word == 32'd0) begin
                                state_q     <= ST_DONE;
                                s_ready_q   <= 1'b0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                cpu_rst_n_q <= 1'b1;
                            end else if (w_hdr_word > C_MAX_WORDS) begin
                                state_q   <= ST_ERR;
                                s_ready_q <= 1'b0;
                                busy_q    <= 1'b0;
                                err_q     <= 1'b1;
                            end else begin
                                state_q <= ST_DATA;
                                addr_q  <= BASE_ADDR;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (w_xfer) begin
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        data_q     <= w_data_word;
                        if (w_last_byte) begin
                            state_q   <= ST_WRITE;
                            s_ready_q <= 1'b0;
                            mm_wr_q   <= MM_WR_W;
                        end
                    end
                end

                ST_WRITE: begin
                    mm_wr_q <= 2'b00;
                    words_q <= w_words_inc;
                    addr_q  <= addr_q + 32'd4;
                    if (w_words_inc == n_q) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cpu_rst_n_q <= 1'b1;
                    end else begin
                        state_q   <= ST_DATA;
                        s_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b0;
                    mm_wr_q   <= 2'b00;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.mm_wr       = mm_wr_q;
    assign bus.mm_addr     = addr_q;
    assign bus.mm_data     = data_q;
    assign cpu_rst_n_o     = cpu_rst_n_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign words_loaded_o  = words_q;

endmodule

`default_nettype wire

// File: tb/tb_mm_boot_loader.sv
//------------------------------------------------------------------------------
// Module  : tb_mm_boot_loader
// Brief   : Scoreboard bench for mm_boot_loader with a randomised image stream.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mm_boot_loader;

    localparam logic [31:0] C_BASE    = 32'h0000_0000;
    localparam int          C_MAX     = 6;
    localparam logic [1:0]  C_WR_W    = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] words;

    mm_boot_loader_if ifc ();

    mm_boot_loader #(
        .BASE_ADDR (C_BASE),
        .MAX_WORDS (C_MAX),
        .MM_WR_W   (C_WR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .bus            (ifc),
        .cpu_rst_n_o    (cpu_rst_n),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .words_loaded_o (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected word
    always @(negedge clk) begin
        if (rst_n && ifc.mm_wr !== 2'b00) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         ifc.mm_addr, ifc.mm_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_code", 32'(ifc.mm_wr), 32'(C_WR_W));
                chk("wr_addr", ifc.mm_addr, mon_e.addr);
                chk("wr_data", ifc.mm_data, mon_e.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        bit acc;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (gap) @(negedge clk);
        ifc.s_valid = 1'b1;
        ifc.s_data  = b;
        acc = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = ifc.s_ready;
            @(negedge clk);
        end
        ifc.s_valid = 1'b0;
        ifc.s_data  = 8'($urandom());
        if (!acc) chk("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[7:0], maxgap);
            v = v >> 8;
        end
    endtask

    task automatic wait_end();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done || err) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready", 32'(ifc.s_ready), 32'd0);
        chk("rst_mm_wr",   32'(ifc.mm_wr),   32'd0);
        chk("rst_mm_addr", ifc.mm_addr,      32'd0);
        chk("rst_mm_data", ifc.mm_data,      32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst_n),   32'd0);
        chk("rst_busy",    32'(busy),        32'd0);
        chk("rst_done",    32'(done),        32'd0);
        chk("rst_err",     32'(err),         32'd0);
        chk("rst_words",   words,            32'd0);
    endtask

    // Reference: word i of an n-word image goes to BASE + 4*i (mod 2^32)
    task automatic run_load(input int n, input int maxgap, input bit poke_start);
        logic [31:0] w;
        pulse_start();
        send_word(32'(n), maxgap);
        chk("hold_cpu", 32'(cpu_rst_n), 32'd0);
        for (int i = 0; i < n; i++) begin
            w = $urandom();
            exp_q.push_back('{addr: C_BASE + 32'(4 * i), data: w});
            if (poke_start && i == 1) pulse_start();
            send_word(w, maxgap);
        end
        wait_end();
        chk("load_done",    32'(done),      32'd1);
        chk("load_cpu_rst", 32'(cpu_rst_n), 32'd1);
        chk("load_busy",    32'(busy),      32'd0);
        chk("load_words",   words,          32'(n));
        chk("load_pending", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        ifc.s_valid = 1'b0;
        ifc.s_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals();

        // Single word 0x000051B7
        pulse_start();
        chk("busy_hdr", 32'(busy), 32'd1);
        send_word(32'd1, 0);
        exp_q.push_back('{addr: C_BASE, data: 32'h0000_51B7});
        send_byte(8'hB7, 0);
        send_byte(8'h51, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("wr_latency", 32'(ifc.mm_wr), 32'(C_WR_W));
        chk("cpu_during_wr", 32'(cpu_rst_n), 32'd0);
        @(negedge clk);
        chk("wr_one_cycle", 32'(ifc.mm_wr), 32'd0);
        chk("single_done",  32'(done),      32'd1);
        chk("single_cpu",   32'(cpu_rst_n), 32'd1);
        chk("single_words", words,          32'd1);

        // Stalled stream, three words
        run_load(3, 3, 1'b0);

        // Empty image: DONE right after the 4th header byte, no write
        pulse_start();
        send_word(32'd0, 2);
        chk("empty_done",  32'(done),      32'd1);
        chk("empty_cpu",   32'(cpu_rst_n), 32'd1);
        chk("empty_words", words,          32'd0);
        repeat (3) @(negedge clk);

        // Oversize header, then all-ones header (unsigned compare)
        pulse_start();
        send_word(32'(C_MAX + 1), 1);
        chk("over_err",   32'(err),        32'd1);
        chk("over_cpu",   32'(cpu_rst_n),  32'd0);
        chk("over_done",  32'(done),       32'd0);
        chk("over_ready", 32'(ifc.s_ready), 32'd0);
        pulse_start();
        chk("err_clear", 32'(err), 32'd0);
        send_word(32'hFFFF_FFFF, 0);
        chk("huge_err", 32'(err), 32'd1);
        run_load(1, 1, 1'b0);
        chk("err_after_ok", 32'(err), 32'd0);

        // Largest accepted image, with a START while busy
        run_load(C_MAX, 2, 1'b1);

        // Mid-load reset after two data bytes of the first word
        pulse_start();
        send_word(32'd2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_load(2, 1, 1'b0);

        // Random images
        for (int k = 0; k < 6; k++) begin
            run_load(int'($urandom_range(C_MAX, 1)), 3, 1'($urandom()));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
